pwm_fifo_sched: RTL and testbench

Duty-cycle scheduler between the PWM sample FIFO (`sync_fifo`) and the PWM output pin. It pops one duty value per PWM period from the FIFO and prefetches the next value into a shadow register, so the new duty takes effect exactly at the period boundary. It generates the PWM waveform and flags underflow. It is the only reader of its FIFO.

---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_period_counter.sv | 42 ++++
 rtl/pwm_fifo_sched.sv | 125 ++++++++++++
 tb/tb_pwm_fifo_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM sample path: scheduler state encoding and data width limits.
package pwm_pkg;

    localparam int PWM_DEFAULT_WIDTH = 8;
    localparam int PWM_MIN_WIDTH     = 1;
    localparam int PWM_MAX_WIDTH     = 63;

    typedef logic [1:0] pwm_state_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

endpackage

// File: rtl/pwm_period_counter.sv
// PWM period counter: counts 0..top, reloads top from i_top at each wrap or on load-zero.
module pwm_period_counter
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_top,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_boundary
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_top;
    logic             w_at_top;

    assign w_at_top   = (r_cnt == r_top);
    assign o_boundary = i_en && w_at_top;
    assign o_cnt      = r_cnt;

    // The top is latched on load-zero and at every wrap, so i_period changes only take effect per period.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_top <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_top <= i_top;
        end else if (i_en) begin
            if (w_at_top) begin
                r_cnt <= '0;
                r_top <= i_top;
            end else begin
                r_cnt <= r_cnt + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_fifo_sched.sv
// PWM duty scheduler: pops one duty per period from sync_fifo, prefetching into a one-deep shadow.
// Build option PWM_SCHED_UNDERFLOW_ZERO_EN: underflow forces duty to 0 instead of repeating the last one.
module pwm_fifo_sched
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_period,
    input  logic             i_fifo_empty,
    input  logic [WIDTH-1:0] i_fifo_data,
    output logic             o_fifo_re,
    output logic             o_pwm,
    output logic [WIDTH-1:0] o_duty,
    output logic             o_underflow,
    output logic             o_busy,
    output pwm_state_t       o_state
);

    pwm_state_t       r_state;
    logic [WIDTH-1:0] r_duty;
    logic [WIDTH-1:0] r_shadow;
    logic             r_shadow_vld;
    logic             r_re;
    logic             r_pf;
    logic             r_cap;
    logic             r_underflow;

    logic [WIDTH-1:0] w_cnt;
    logic             w_bnd;
    logic             w_run;
    logic             w_clr;
    logic             w_pending;
    logic             w_prefetch;
    logic             w_start_shadow;
    logic             w_start_fetch;
    logic             w_take_shadow;
    logic             w_bypass;
    logic             w_starve;

    // FIFO read handshake: o_fifo_re is a one-cycle request raised only after a non-empty flag;
    // i_fifo_data is valid exactly one cycle later and is always consumed in that cycle.
    assign w_run          = (r_state == ST_RUN);
    assign w_pending      = r_re || r_cap;
    assign w_prefetch     = w_run && !r_shadow_vld && !w_pending && !i_fifo_empty;
    assign w_start_shadow = (r_state == ST_IDLE) && i_en && r_shadow_vld;
    assign w_start_fetch  = (r_state == ST_IDLE) && i_en && !r_shadow_vld && !w_pending && !i_fifo_empty;
    assign w_clr          = w_start_shadow || (r_state == ST_CAPTURE);
    assign w_take_shadow  = w_bnd && i_en && r_shadow_vld;
    assign w_bypass       = w_bnd && i_en && !r_shadow_vld && r_cap;
    assign w_starve       = w_bnd && i_en && !r_shadow_vld && !r_cap;

    pwm_period_counter #(.WIDTH(WIDTH)) u_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (w_clr),
        .i_en       (w_run),
        .i_top      (i_period),
        .o_cnt      (w_cnt),
        .o_boundary (w_bnd)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_duty       <= '0;
            r_shadow     <= '0;
            r_shadow_vld <= 1'b0;
            r_re         <= 1'b0;
            r_pf         <= 1'b0;
            r_cap        <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_re        <= w_start_fetch || w_prefetch;
            r_pf        <= w_prefetch;
            r_cap       <= r_re && r_pf;
            r_underflow <= w_starve;

            case (r_state)
                ST_IDLE: begin
                    if (w_start_shadow)
                        r_state <= ST_RUN;
                    else if (w_start_fetch)
                        r_state <= ST_FETCH;
                end
                ST_FETCH:   r_state <= ST_CAPTURE;
                ST_CAPTURE: r_state <= ST_RUN;
                ST_RUN: begin
                    if (w_bnd && !i_en)
                        r_state <= ST_IDLE;
                end
                default:    r_state <= ST_IDLE;
            endcase

            if (r_state == ST_CAPTURE)
                r_duty <= i_fifo_data;
            else if (w_start_shadow || w_take_shadow)
                r_duty <= r_shadow;
            else if (w_bypass)
                r_duty <= i_fifo_data;
`ifdef PWM_SCHED_UNDERFLOW_ZERO_EN
            else if (w_starve)
                r_duty <= '0;
`endif

            // A prefetched word landing on a boundary goes straight to the duty and never parks.
            if (w_start_shadow || w_take_shadow) begin
                r_shadow_vld <= 1'b0;
            end else if (r_cap && !w_bypass) begin
                r_shadow     <= i_fifo_data;
                r_shadow_vld <= 1'b1;
            end
        end
    end

    assign o_fifo_re   = r_re;
    assign o_duty      = r_duty;
    assign o_underflow = r_underflow;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_pwm       = w_run && (w_cnt < r_duty);
    assign o_state     = r_state;

endmodule

// File: tb/tb_pwm_fifo_sched.sv
// Bench for pwm_fifo_sched: queue-based FIFO model, period-level waveform reference, directed + random streams.
// Expectations follow the PWM_SCHED_UNDERFLOW_ZERO_EN setting of the build.
module tb_pwm_fifo_sched;
    import pwm_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_en = 1'b0;
    logic [W-1:0] i_period = '0;
    logic         fifo_empty = 1'b1;
    logic [W-1:0] fifo_data = '0;
    logic         o_fifo_re;
    logic         o_pwm;
    logic [W-1:0] o_duty;
    logic         o_underflow;
    logic         o_busy;
    pwm_state_t   o_state;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] stim_q[$];
    logic [W-1:0] exp_q[$];
    int           n_pass = 0;
    int           n_checks = 0;
    int           n_reads = 0;

    pwm_fifo_sched #(.WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (i_en),
        .i_period     (i_period),
        .i_fifo_empty (fifo_empty),
        .i_fifo_data  (fifo_data),
        .o_fifo_re    (o_fifo_re),
        .o_pwm        (o_pwm),
        .o_duty       (o_duty),
        .o_underflow  (o_underflow),
        .o_busy       (o_busy),
        .o_state      (o_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One clock; the FIFO model pops on a read seen during the cycle just ended.
    task automatic tick();
        logic re_now;
        re_now = o_fifo_re;
        @(posedge clk);
        #1;
        if (re_now) begin
            n_reads++;
            check("re_when_empty", 64'(fifo_q.size() == 0), 64'(0));
            if (fifo_q.size() > 0)
                fifo_data = fifo_q.pop_front();
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic do_reset();
        i_en = 1'b0;
        rst = 1'b1;
        fifo_q.delete();
        fifo_empty = 1'b1;
        fifo_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_reads = 0;
    endtask

    task automatic preload();
        foreach (stim_q[i]) fifo_q.push_back(stim_q[i]);
        fifo_empty = (fifo_q.size() == 0);
    endtask

    // Start from IDLE, play stim_q then n_extra starved periods, drop i_en for one last period.
    // fixed_per < 0 picks a fresh random period top (2..9) for every period.
    task automatic run_stream(input int fixed_per, input int n_extra);
        logic [W-1:0] d;
        logic [W-1:0] last;
        logic         uf;
        int           cur;
        int           nxt;
        int           total;
        total = stim_q.size() + n_extra;
        exp_q.delete();
        foreach (stim_q[i]) exp_q.push_back(stim_q[i]);
        preload();
        cur = (fixed_per >= 0) ? fixed_per : int'($urandom_range(2, 9));
        i_period = W'(cur);
        i_en = 1'b1;
        tick();
        check("fetch_re", 64'(o_fifo_re), 64'(1));
        check("fetch_busy", 64'(o_busy), 64'(1));
        tick();
        check("capture_re", 64'(o_fifo_re), 64'(0));
        check("capture_pwm", 64'(o_pwm), 64'(0));
        last = '0;
        for (int k = 0; k <= total; k++) begin
            if (exp_q.size() > 0) begin
                d  = exp_q.pop_front();
                uf = 1'b0;
            end else begin
                uf = 1'b1;
`ifdef PWM_SCHED_UNDERFLOW_ZERO_EN
                d = '0;
`else
                d = last;
`endif
            end
            last = d;
            nxt = (fixed_per >= 0) ? fixed_per : int'($urandom_range(2, 9));
            for (int c = 0; c <= cur; c++) begin
                tick();
                if (c == 0) begin
                    check("duty", 64'(o_duty), 64'(d));
                    i_period = W'(nxt);
                    if (k == total)
                        i_en = 1'b0;
                end
                check("underflow", 64'(o_underflow), 64'((c == 0) && uf));
                check("pwm", 64'(o_pwm), 64'(c < int'(d)));
                check("busy", 64'(o_busy), 64'(1));
            end
            cur = nxt;
        end
        tick();
        check("stop_busy", 64'(o_busy), 64'(0));
        check("stop_pwm", 64'(o_pwm), 64'(0));
        check("stop_underflow", 64'(o_underflow), 64'(0));
    endtask

    initial begin
        do_reset();
        check("rst_pwm", 64'(o_pwm), 64'(0));
        check("rst_re", 64'(o_fifo_re), 64'(0));
        check("rst_duty", 64'(o_duty), 64'(0));
        check("rst_underflow", 64'(o_underflow), 64'(0));
        check("rst_busy", 64'(o_busy), 64'(0));
        check("rst_state", 64'(o_state), 64'(ST_IDLE));

        // Basic start, then seamless update, underflow and duty extremes.
        stim_q = {8'd3, 8'd3, 8'd3};
        run_stream(7, 0);
        do_reset();
        stim_q = {8'd2, 8'd6};
        run_stream(9, 0);
        do_reset();
        stim_q = {8'd4};
        run_stream(7, 2);
        check("underflow_reads", 64'(n_reads), 64'(1));
        do_reset();
        stim_q = {8'd0, 8'd9};
        run_stream(7, 0);

        // Stop mid-period with 5 parked in the shadow, then restart from the shadow.
        do_reset();
        stim_q = {8'd1, 8'd5};
        preload();
        i_period = 8'd7;
        i_en = 1'b1;
        tick();
        tick();
        for (int c = 0; c <= 7; c++) begin
            tick();
            if (c == 4)
                i_en = 1'b0;
            check("stop_pwm_run", 64'(o_pwm), 64'(c < 1));
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            check("idle_busy", 64'(o_busy), 64'(0));
            check("idle_pwm", 64'(o_pwm), 64'(0));
            check("idle_re", 64'(o_fifo_re), 64'(0));
        end
        i_en = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            tick();
            if (c == 0) begin
                check("restart_busy", 64'(o_busy), 64'(1));
                check("restart_duty", 64'(o_duty), 64'(5));
            end
            check("restart_re", 64'(o_fifo_re), 64'(0));
            check("restart_pwm", 64'(o_pwm), 64'(c < 5));
        end
        check("restart_reads", 64'(n_reads), 64'(2));

        // Reset while a prefetch read is in flight; that word is lost.
        do_reset();
        stim_q = {8'd7, 8'd2, 8'd11};
        preload();
        i_period = 8'd5;
        i_en = 1'b1;
        repeat (3) tick();
        check("mid_duty", 64'(o_duty), 64'(7));
        tick();
        check("mid_pf_re", 64'(o_fifo_re), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check("arst_pwm", 64'(o_pwm), 64'(0));
        check("arst_re", 64'(o_fifo_re), 64'(0));
        check("arst_duty", 64'(o_duty), 64'(0));
        check("arst_underflow", 64'(o_underflow), 64'(0));
        check("arst_busy", 64'(o_busy), 64'(0));
        void'(fifo_q.pop_front());
        i_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        fifo_empty = (fifo_q.size() == 0);
        repeat (2) begin
            tick();
            check("post_rst_busy", 64'(o_busy), 64'(0));
            check("post_rst_re", 64'(o_fifo_re), 64'(0));
        end
        i_en = 1'b1;
        tick();
        check("post_rst_fetch", 64'(o_fifo_re), 64'(1));
        tick();
        tick();
        check("post_rst_duty", 64'(o_duty), 64'(11));
        check("post_rst_run", 64'(o_busy), 64'(1));

        // Random duties (including over-period) with random per-period tops.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            stim_q.delete();
            for (int i = 0; i < 5; i++)
                stim_q.push_back(W'($urandom_range(0, 12)));
            run_stream(-1, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
